// File: rtl/y_serial_adder.sv
// Digit-serial adder: adds D bits per clock, LSB digit first, one result per N+1 cycles.
// Optional macro Y_SERIAL_ADDER_SUB_EN adds a 'sub' input selecting a - b.
module y_serial_adder #(
   parameter int unsigned W = 32,
   parameter int unsigned D = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
`ifdef Y_SERIAL_ADDER_SUB_EN
   input  logic         sub,
`endif
   output logic         ready,
   output logic         done,
   output logic [W-1:0] z,
   output logic         cout,
   output logic         ovf
);

   localparam int unsigned N  = W / D;
   localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d, b_q, b_d, z_q, z_d;
   logic            c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
   logic [KW-1:0]   k_q, k_d;
   logic [D:0]      sum;
   logic            inv;

`ifdef Y_SERIAL_ADDER_SUB_EN
   assign inv = sub;
`else
   assign inv = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         z_q     <= '0;
         c_q     <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         z_q     <= z_d;
         c_q     <= c_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         k_q     <= k_d;
      end
   end

   // Operands shift right so digit k always sits in the low D bits; z is written in place.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      z_d     = z_q;
      c_d     = c_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      k_d     = k_q;
      sum     = {1'b0, a_q[D-1:0]} + {1'b0, b_q[D-1:0]} + (D+1)'(c_q);
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               // Subtraction is a + ~b + 1, so the inversion and forced carry happen at latch time.
               a_d     = a;
               b_d     = b ^ {W{inv}};
               c_d     = inv ? 1'b1 : cin;
               k_d     = '0;
               z_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d = a_q >> D;
            b_d = b_q >> D;
            c_d = sum[D];
            k_d = k_q + KW'(1);
            for (int unsigned i = 0; i < N; i++) begin
               if (k_q == KW'(i)) z_d[i*D +: D] = sum[D-1:0];
            end
            if (k_q == KW'(N-1)) begin
               k_d     = '0;
               cout_d  = sum[D];
               // Carry into the MSB recovered from the MSB sum bit.
               ovf_d   = sum[D] ^ (a_q[D-1] ^ b_q[D-1] ^ sum[D-1]);
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ready = (state_q != RUN);
   assign done  = (state_q == DONE);
   assign z     = z_q;
   assign cout  = cout_q;
   assign ovf   = ovf_q;

endmodule
